park_slot_manager: RTL and testbench

Sequential, parametrised slot manager for the smart parking main module, succeeding the combinational exit lookup. It tracks occupancy of `SLOTS` bays, allocates the lowest free bay on entry, and issues a token. It stores a per-bay exit pattern and releases a bay only when the token and pattern match. It counts consecutive failed exit attempts and raises a latched alarm.

---
 rtl/park_slot_manager.sv | 191 +++++++++++++++++++
 tb/tb_park_slot_manager.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/park_slot_manager.sv
// -----------------------------------------------------------------------------
// park_slot_manager
// Tracks occupancy of SLOTS parking bays. On entry it allocates the lowest
// free bay, remembers that bay's exit pattern and returns the bay index as a
// token. On exit it releases the bay only if the token, occupancy and stored
// pattern all agree. Consecutive failed exits are counted, and reaching
// MAX_FAIL latches an alarm that blocks all exits until alarm_clr.
//
// Ports
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   entry             : entry request (one request per cycle while high)
//   entry_pattern     : pattern stored into the bay allocated by this entry
//   exit              : exit request (one request per cycle while high)
//   token, pattern    : bay index and pattern presented on exit
//   alarm_clr         : clears the alarm and the fail counter
//   park_location     : occupancy vector, bit i set = bay i occupied
//   free_count, full  : free bay count and lot-full flag (from occupancy)
//   grant, token_out  : entry accepted pulse and allocated bay index
//   entry_rej         : entry rejected pulse (lot full)
//   exit_ok, exit_err : exit accepted / rejected pulses
//   alarm             : latched alarm
// -----------------------------------------------------------------------------
module park_slot_manager #(
    parameter int SLOTS     = 8,
    parameter int TOKEN_W   = 3,
    parameter int PATTERN_W = 3,
    parameter int MAX_FAIL  = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         entry,
    input  logic [PATTERN_W-1:0]         entry_pattern,
    input  logic                         exit,
    input  logic [TOKEN_W-1:0]           token,
    input  logic [PATTERN_W-1:0]         pattern,
    input  logic                         alarm_clr,
    output logic [SLOTS-1:0]             park_location,
    output logic [$clog2(SLOTS+1)-1:0]   free_count,
    output logic                         full,
    output logic                         grant,
    output logic [TOKEN_W-1:0]           token_out,
    output logic                         entry_rej,
    output logic                         exit_ok,
    output logic                         exit_err,
    output logic                         alarm
);

    localparam int FREE_W = $clog2(SLOTS + 1);

    logic [SLOTS-1:0]     occ_r;
    logic [PATTERN_W-1:0] pat_mem_r [SLOTS];
    logic [3:0]           fail_r;
    logic                 alarm_r;
    logic                 grant_r;
    logic [TOKEN_W-1:0]   token_out_r;
    logic                 entry_rej_r;
    logic                 exit_ok_r;
    logic                 exit_err_r;

    logic                 free_found_s;
    logic [TOKEN_W-1:0]   free_idx_s;
    logic                 tok_occ_s;
    logic [PATTERN_W-1:0] tok_pat_s;
    logic                 exit_valid_s;
    logic                 alloc_s;
    logic [SLOTS-1:0]     occ_next_s;
    logic [3:0]           fail_inc_s;
    logic [3:0]           fail_next_s;
    logic                 alarm_next_s;
    logic [FREE_W-1:0]    used_cnt_s;

    // Lowest free bay: scanning downward leaves the lowest zero bit last.
    always_comb begin
        free_found_s = 1'b0;
        free_idx_s   = {TOKEN_W{1'b0}};
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!occ_r[i]) begin
                free_found_s = 1'b1;
                free_idx_s   = TOKEN_W'(i);
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    // Look up the bay addressed by token; an out-of-range token matches no bay
    // and therefore reads as unoccupied, which makes the exit invalid.
    always_comb begin
        tok_occ_s = 1'b0;
        tok_pat_s = {PATTERN_W{1'b0}};
        for (int i = 0; i < SLOTS; i++) begin
            if (token == TOKEN_W'(i)) begin
                tok_occ_s = occ_r[i];
                tok_pat_s = pat_mem_r[i];
            end else begin
                tok_occ_s = tok_occ_s;
            end
        end
    end

    assign exit_valid_s = exit && tok_occ_s && (tok_pat_s == pattern) && !alarm_r;
    assign alloc_s      = entry && free_found_s;

    // Next occupancy: the allocated bay is always free and the released bay is
    // always occupied, so the two updates never touch the same bit.
    always_comb begin
        occ_next_s = occ_r;
        for (int i = 0; i < SLOTS; i++) begin
            if (alloc_s && (free_idx_s == TOKEN_W'(i))) begin
                occ_next_s[i] = 1'b1;
            end else if (exit_valid_s && (token == TOKEN_W'(i))) begin
                occ_next_s[i] = 1'b0;
            end else begin
                occ_next_s[i] = occ_r[i];
            end
        end
    end

    assign fail_inc_s = (fail_r == 4'd15) ? 4'd15 : (fail_r + 4'd1);

    // Fail counter and alarm: alarm_clr has priority over a failing exit.
    always_comb begin
        fail_next_s  = fail_r;
        alarm_next_s = alarm_r;
        if (alarm_clr) begin
            fail_next_s  = 4'd0;
            alarm_next_s = 1'b0;
        end else if (exit_valid_s) begin
            fail_next_s  = 4'd0;
            alarm_next_s = alarm_r;
        end else if (exit) begin
            fail_next_s  = fail_inc_s;
            alarm_next_s = alarm_r || (fail_inc_s >= 4'(MAX_FAIL));
        end else begin
            fail_next_s  = fail_r;
            alarm_next_s = alarm_r;
        end
    end

    // Occupied bay count for free_count / full.
    always_comb begin
        used_cnt_s = {FREE_W{1'b0}};
        for (int i = 0; i < SLOTS; i++) begin
            used_cnt_s = used_cnt_s + {{(FREE_W-1){1'b0}}, occ_r[i]};
        end
    end

    // State and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_r       <= {SLOTS{1'b0}};
            fail_r      <= 4'd0;
            alarm_r     <= 1'b0;
            grant_r     <= 1'b0;
            token_out_r <= {TOKEN_W{1'b0}};
            entry_rej_r <= 1'b0;
            exit_ok_r   <= 1'b0;
            exit_err_r  <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                pat_mem_r[i] <= {PATTERN_W{1'b0}};
            end
        end else begin
            occ_r       <= occ_next_s;
            fail_r      <= fail_next_s;
            alarm_r     <= alarm_next_s;
            grant_r     <= alloc_s;
            token_out_r <= alloc_s ? free_idx_s : token_out_r;
            entry_rej_r <= entry && !free_found_s;
            exit_ok_r   <= exit_valid_s;
            exit_err_r  <= exit && !exit_valid_s;
            for (int i = 0; i < SLOTS; i++) begin
                if (alloc_s && (free_idx_s == TOKEN_W'(i))) begin
                    pat_mem_r[i] <= entry_pattern;
                end else begin
                    pat_mem_r[i] <= pat_mem_r[i];
                end
            end
        end
    end

    assign park_location = occ_r;
    assign free_count    = FREE_W'(SLOTS) - used_cnt_s;
    assign full          = (free_count == {FREE_W{1'b0}});
    assign grant         = grant_r;
    assign token_out     = token_out_r;
    assign entry_rej     = entry_rej_r;
    assign exit_ok       = exit_ok_r;
    assign exit_err      = exit_err_r;
    assign alarm         = alarm_r;

endmodule

// File: tb/tb_park_slot_manager.sv
// -----------------------------------------------------------------------------
// tb_park_slot_manager
// Directed scenarios followed by random traffic, every cycle compared against a
// bay-list reference model of the parking rules.
// -----------------------------------------------------------------------------
module tb_park_slot_manager;

    localparam int SLOTS     = 8;
    localparam int TOKEN_W   = 3;
    localparam int PATTERN_W = 3;
    localparam int MAX_FAIL  = 3;
    localparam int FREE_W    = $clog2(SLOTS + 1);

    logic                 clk;
    logic                 rst_n;
    logic                 entry;
    logic [PATTERN_W-1:0] entry_pattern;
    logic                 exit;
    logic [TOKEN_W-1:0]   token;
    logic [PATTERN_W-1:0] pattern;
    logic                 alarm_clr;
    logic [SLOTS-1:0]     park_location;
    logic [FREE_W-1:0]    free_count;
    logic                 full;
    logic                 grant;
    logic [TOKEN_W-1:0]   token_out;
    logic                 entry_rej;
    logic                 exit_ok;
    logic                 exit_err;
    logic                 alarm;

    park_slot_manager #(
        .SLOTS(SLOTS), .TOKEN_W(TOKEN_W), .PATTERN_W(PATTERN_W), .MAX_FAIL(MAX_FAIL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .entry(entry), .entry_pattern(entry_pattern),
        .exit(exit), .token(token), .pattern(pattern), .alarm_clr(alarm_clr),
        .park_location(park_location), .free_count(free_count), .full(full),
        .grant(grant), .token_out(token_out), .entry_rej(entry_rej),
        .exit_ok(exit_ok), .exit_err(exit_err), .alarm(alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: one flag and one pattern per bay, plus counters.
    bit                   occ_m [SLOTS];
    logic [PATTERN_W-1:0] pat_m [SLOTS];
    int                   fail_m;
    bit                   alarm_m;
    int                   tok_m;
    bit                   grant_m, rej_m, ok_m, err_m;

    task automatic model_reset();
        for (int i = 0; i < SLOTS; i++) begin
            occ_m[i] = 1'b0;
            pat_m[i] = '0;
        end
        fail_m = 0; alarm_m = 1'b0; tok_m = 0;
        grant_m = 1'b0; rej_m = 1'b0; ok_m = 1'b0; err_m = 1'b0;
    endtask

    task automatic model_cycle(input bit en, input logic [PATTERN_W-1:0] ep,
                               input bit ex, input logic [TOKEN_W-1:0] tk,
                               input logic [PATTERN_W-1:0] pt, input bit clr);
        int  first_free;
        bit  valid;
        first_free = -1;
        for (int i = 0; i < SLOTS; i++)
            if (!occ_m[i] && first_free < 0) first_free = i;
        valid = ex && (int'(tk) < SLOTS) && occ_m[tk] && (pat_m[tk] == pt) && !alarm_m;
        grant_m = 1'b0; rej_m = 1'b0; ok_m = 1'b0; err_m = 1'b0;
        if (en) begin
            if (first_free >= 0) begin
                occ_m[first_free] = 1'b1;
                pat_m[first_free] = ep;
                grant_m = 1'b1;
                tok_m   = first_free;
            end else begin
                rej_m = 1'b1;
            end
        end
        if (ex) begin
            if (valid) begin
                occ_m[tk] = 1'b0;
                fail_m    = 0;
                ok_m      = 1'b1;
            end else begin
                err_m  = 1'b1;
                fail_m = (fail_m < 15) ? fail_m + 1 : 15;
                if (fail_m >= MAX_FAIL) alarm_m = 1'b1;
            end
        end
        if (clr) begin
            fail_m  = 0;
            alarm_m = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("compare %s", tag);
        end
    endtask

    task automatic check_all(input string tag);
        logic [SLOTS-1:0] loc;
        int               used;
        used = 0;
        for (int i = 0; i < SLOTS; i++) begin
            loc[i] = occ_m[i];
            used += int'(occ_m[i]);
        end
        chk({tag, ".park_location"}, 32'(park_location), 32'(loc));
        chk({tag, ".free_count"},    32'(free_count),    32'(SLOTS - used));
        chk({tag, ".full"},          32'(full),          32'(used == SLOTS));
        chk({tag, ".grant"},         32'(grant),         32'(grant_m));
        chk({tag, ".token_out"},     32'(token_out),     32'(tok_m));
        chk({tag, ".entry_rej"},     32'(entry_rej),     32'(rej_m));
        chk({tag, ".exit_ok"},       32'(exit_ok),       32'(ok_m));
        chk({tag, ".exit_err"},      32'(exit_err),      32'(err_m));
        chk({tag, ".alarm"},         32'(alarm),         32'(alarm_m));
    endtask

    // One clock cycle of requests; called at posedge+1, returns at posedge+1.
    task automatic step(input string tag, input bit en, input logic [PATTERN_W-1:0] ep,
                        input bit ex, input logic [TOKEN_W-1:0] tk,
                        input logic [PATTERN_W-1:0] pt, input bit clr);
        entry = en; entry_pattern = ep; exit = ex; token = tk; pattern = pt; alarm_clr = clr;
        @(posedge clk);
        model_cycle(en, ep, ex, tk, pt, clr);
        #1;
        check_all(tag);
    endtask

    initial begin
        bit                   r_en, r_ex, r_clr;
        logic [TOKEN_W-1:0]   r_tk;
        logic [PATTERN_W-1:0] r_ep, r_pt;

        rst_n = 1'b0; entry = 1'b0; entry_pattern = '0; exit = 1'b0;
        token = '0; pattern = '0; alarm_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Fill the lot, then one entry too many.
        for (int i = 0; i < SLOTS; i++) step("fill", 1'b1, 3'b101, 1'b0, 3'd0, 3'd0, 1'b0);
        step("fill_rej", 1'b1, 3'b101, 1'b0, 3'd0, 3'd0, 1'b0);

        // Release bay 3 and reuse it.
        step("exit3",    1'b0, 3'b000, 1'b1, 3'd3, 3'b101, 1'b0);
        step("reuse3",   1'b1, 3'b101, 1'b0, 3'd0, 3'd0,   1'b0);

        // Failures, alarm, blocked exit, clear, good exit.
        step("exit7",    1'b0, 3'b000, 1'b1, 3'd7, 3'b101, 1'b0);
        step("badpat",   1'b0, 3'b000, 1'b1, 3'd2, 3'b100, 1'b0);
        step("emptybay", 1'b0, 3'b000, 1'b1, 3'd7, 3'b101, 1'b0);
        step("fail3",    1'b0, 3'b000, 1'b1, 3'd2, 3'b100, 1'b0);
        step("alarmed",  1'b0, 3'b000, 1'b1, 3'd2, 3'b101, 1'b0);
        step("clr",      1'b0, 3'b000, 1'b0, 3'd0, 3'd0,   1'b1);
        step("exit2",    1'b0, 3'b000, 1'b1, 3'd2, 3'b101, 1'b0);

        // Refill, then full lot with a concurrent entry and valid exit.
        step("refill2",  1'b1, 3'b101, 1'b0, 3'd0, 3'd0,   1'b0);
        step("refill7",  1'b1, 3'b101, 1'b0, 3'd0, 3'd0,   1'b0);
        step("both",     1'b1, 3'b101, 1'b1, 3'd5, 3'b101, 1'b0);
        step("reuse5",   1'b1, 3'b101, 1'b0, 3'd0, 3'd0,   1'b0);

        // Valid exit in between resets the consecutive-failure count.
        step("f1",       1'b0, 3'b000, 1'b1, 3'd1, 3'b100, 1'b0);
        step("f2",       1'b0, 3'b000, 1'b1, 3'd1, 3'b100, 1'b0);
        step("ok1",      1'b0, 3'b000, 1'b1, 3'd1, 3'b101, 1'b0);
        step("f3",       1'b0, 3'b000, 1'b1, 3'd0, 3'b100, 1'b0);
        step("f4",       1'b0, 3'b000, 1'b1, 3'd0, 3'b100, 1'b0);

        // Asynchronous reset while an entry is waiting for its edge.
        step("pre_rst",  1'b1, 3'b011, 1'b0, 3'd0, 3'd0,   1'b0);
        entry = 1'b1; entry_pattern = 3'b011;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        entry = 1'b0;
        @(posedge clk);
        #1;
        check_all("rst_hold");
        rst_n = 1'b1;
        step("rst_release", 1'b0, 3'b000, 1'b0, 3'd0, 3'd0, 1'b0);

        // Random traffic, exits mostly presenting the remembered pattern.
        for (int n = 0; n < 400; n++) begin
            r_en  = ($urandom_range(0, 1) == 1);
            r_ex  = ($urandom_range(0, 1) == 1);
            r_clr = ($urandom_range(0, 19) == 0);
            r_tk  = TOKEN_W'($urandom_range(0, SLOTS - 1));
            r_ep  = PATTERN_W'($urandom_range(0, 7));
            r_pt  = ($urandom_range(0, 9) < 7) ? pat_m[r_tk] : PATTERN_W'($urandom_range(0, 7));
            step("rand", r_en, r_ep, r_ex, r_tk, r_pt, r_clr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
